// File: rtl/key_expander.sv
// AES key schedule (NK = 4/6/8): one 128-bit round key per cycle from a sliding NK-word window.
// Registered outputs, round 0 one cycle after start; no backpressure, the schedule free-runs to round Nr.
module key_expander #(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [32*NK-1:0] key,
  output logic [127:0]    round_key,
  output logic            rk_valid,
  output logic [3:0]      rk_round,
  output logic            busy,
  output logic            done
);

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("key_expander: NK must be 4, 6 or 8");
    end
  endgenerate

  localparam logic [3:0] NK4 = 4'(NK);
  localparam logic [3:0] NR4 = 4'(NK + 6);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [32*NK-1:0] key_q;
  logic [31:0]      win [NK];
  logic [31:0]      kw [NK];
  logic [31:0]      nw [4];
  logic [7:0]       rcon;
  logic [3:0]       nbase, nbase_nxt;
  logic [3:0]       from_key;
  logic [1:0]       jspec;
  logic             spec_vld, spec_rot, advance;
  logic [31:0]      sub_in, sub_out, temp_spec, prv, tmp;
  logic [3:0]       p;

  always_comb begin
    for (int k = 0; k < NK; k++) kw[k] = key_q[32*(NK-k)-1 -: 32];
  end

  // Word positions mod NK; at most one word per group needs the S-box.
  always_comb begin
    from_key = '0;
    spec_vld = 1'b0;
    spec_rot = 1'b0;
    jspec    = 2'd0;
    p        = '0;
    for (int j = 0; j < 4; j++) begin
      p = nbase + 4'(j);
      if (p >= NK4) p = p - NK4;
      from_key[j] = (rk_round == 4'd0) && (j + 4 < NK);
      if (!from_key[j] && (p == 4'd0 || (NK == 8 && p == 4'd4))) begin
        spec_vld = 1'b1;
        spec_rot = (p == 4'd0);
        jspec    = 2'(j);
      end
    end
    nbase_nxt = nbase + 4'd4;
    if (nbase_nxt >= NK4) nbase_nxt = nbase_nxt - NK4;
  end

  // First pass finds the S-box input (words before it never need the S-box), second builds the group.
  always_comb begin
    sub_in = win[NK-1];
    prv    = win[NK-1];
    for (int j = 0; j < 4; j++) begin
      if (2'(j) == jspec) sub_in = prv;
      prv = from_key[j] ? kw[(j+4) % NK] : (win[j] ^ prv);
    end
    sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    temp_spec = spec_rot ? ({sub_out[23:0], sub_out[31:24]} ^ {rcon, 24'h0}) : sub_out;
    prv = win[NK-1];
    tmp = '0;
    for (int j = 0; j < 4; j++) begin
      tmp   = (spec_vld && 2'(j) == jspec) ? temp_spec : prv;
      nw[j] = from_key[j] ? kw[(j+4) % NK] : (win[j] ^ tmp);
      prv   = nw[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rk_valid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: ;
      RUN: begin
        rk_valid = 1'b1;
        if (rk_round == NR4) begin
          done      = 1'b1;
          state_nxt = DONE;
        end else begin
          busy    = 1'b1;
          advance = 1'b1;
        end
      end
      DONE: done = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q     <= '0;
      for (int k = 0; k < NK; k++) win[k] <= '0;
      rcon      <= 8'h00;
      nbase     <= 4'd0;
      round_key <= '0;
      rk_round  <= 4'd0;
    end else if (start) begin
      key_q     <= key;
      for (int k = 0; k < NK - 4; k++) win[k] <= '0;
      for (int m = 0; m < 4; m++) win[NK-4+m] <= key[32*(NK-m)-1 -: 32];
      round_key <= key[32*NK-1 -: 128];
      rk_round  <= 4'd0;
      rcon      <= 8'h01;
      nbase     <= 4'(4 % NK);
    end else if (advance) begin
      round_key <= {nw[0], nw[1], nw[2], nw[3]};
      rk_round  <= rk_round + 4'd1;
      for (int k = 0; k < NK - 4; k++) win[k] <= win[k+4];
      for (int m = 0; m < 4; m++) win[NK-4+m] <= nw[m];
      if (spec_vld && spec_rot) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      nbase     <= nbase_nxt;
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Directed bench: FIPS-197 key schedules for NK=4/6/8, restart, reset and DONE hold.
module tb_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [127:0] rk4, rk6, rk8;
  logic [3:0]   r4, r6, r8;
  logic         v4, v6, v8, b4, b6, b8, d4, d6, d8;
  logic [6:0]   st4, st6, st8;

  assign st4 = {r4, v4, b4, d4};
  assign st6 = {r6, v6, b6, d6};
  assign st8 = {r8, v8, b8, d8};

  key_expander #(.NK(4)) u4 (.clk(clk), .reset(reset), .start(start4), .key(key4),
    .round_key(rk4), .rk_valid(v4), .rk_round(r4), .busy(b4), .done(d4));
  key_expander #(.NK(6)) u6 (.clk(clk), .reset(reset), .start(start6), .key(key6),
    .round_key(rk6), .rk_valid(v6), .rk_round(r6), .busy(b6), .done(d6));
  key_expander #(.NK(8)) u8 (.clk(clk), .reset(reset), .start(start8), .key(key8),
    .round_key(rk8), .rk_valid(v8), .rk_round(r8), .busy(b8), .done(d8));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] K4     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K4_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K4_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K4_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // status = {rk_round, rk_valid, busy, done}
  initial begin
    reset = 1'b1; start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    tick(); tick();
    check("rst_rk4", rk4, 128'h0);
    check("rst_st4", st4, 7'd0);
    check("rst_st6", st6, 7'd0);
    check("rst_st8", st8, 7'd0);
    reset = 1'b0;
    tick();
    check("idle_st4", st4, 7'd0);

    // AES-128 schedule
    key4 = K4; start4 = 1'b1; tick(); start4 = 1'b0;
    check("c1_r0", rk4, K4);
    check("c1_st0", st4, {4'd0, 3'b110});
    tick();
    check("c1_r1", rk4, K4_R1);
    tick();
    check("c1_r2", rk4, K4_R2);
    repeat (7) tick();
    check("c1_st9", st4, {4'd9, 3'b110});
    tick();
    check("c1_r10", rk4, K4_R10);
    check("c1_st10", st4, {4'd10, 3'b101});

    // DONE is sticky and holds the final key
    for (int i = 0; i < 20; i++) begin
      tick();
      check("c6_hold_rk", rk4, K4_R10);
      check("c6_hold_st", st4, {4'd10, 3'b001});
    end
    start4 = 1'b1; tick(); start4 = 1'b0;
    key4 = '1;
    check("c6_rerun_r0", rk4, K4);
    check("c6_rerun_st0", st4, {4'd0, 3'b110});
    tick();
    check("c6_rerun_r1", rk4, K4_R1);
    repeat (9) tick();
    check("c6_rerun_r10", rk4, K4_R10);
    check("c6_rerun_st10", st4, {4'd10, 3'b101});

    // restart mid-schedule with an all-zero key
    key4 = K4; start4 = 1'b1; tick(); start4 = 1'b0;
    repeat (5) tick();
    check("c4_st5", st4, {4'd5, 3'b110});
    key4 = '0; start4 = 1'b1; tick(); start4 = 1'b0;
    check("c4_r0", rk4, 128'h0);
    check("c4_st0", st4, {4'd0, 3'b110});
    tick();
    check("c4_r1", rk4, 128'h62636363626363636263636362636363);
    check("c4_st1", st4, {4'd1, 3'b110});

    // reset mid-schedule, start held during reset is ignored
    key4 = K4; start4 = 1'b1; tick(); start4 = 1'b0;
    repeat (3) tick();
    check("c5_st3", st4, {4'd3, 3'b110});
    reset = 1'b1; start4 = 1'b1;
    tick();
    check("c5_rk", rk4, 128'h0);
    check("c5_st", st4, 7'd0);
    tick();
    check("c5_st_hold", st4, 7'd0);
    reset = 1'b0; start4 = 1'b0;
    tick();
    check("c5_idle_st", st4, 7'd0);
    check("c5_idle_rk", rk4, 128'h0);

    // AES-192 schedule
    key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    start6 = 1'b1; tick(); start6 = 1'b0;
    check("c2_r0", rk6, 128'h8e73b0f7da0e6452c810f32b809079e5);
    tick();
    check("c2_r1", rk6, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    repeat (10) tick();
    check("c2_st11", st6, {4'd11, 3'b110});
    tick();
    check("c2_r12_w51", rk6[31:0], 32'h01002202);
    check("c2_st12", st6, {4'd12, 3'b101});
    tick();
    check("c2_done", st6, {4'd12, 3'b001});

    // AES-256 schedule
    key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    start8 = 1'b1; tick(); start8 = 1'b0;
    check("c3_r0", rk8, 128'h603deb1015ca71be2b73aef0857d7781);
    tick();
    check("c3_r1", rk8, 128'h1f352c073b6108d72d9810a30914dff4);
    tick();
    check("c3_r2_hi", rk8[127:64], 64'h9ba354118e6925af);
    repeat (12) tick();
    check("c3_r14", rk8, 128'hfe4890d1e6188d0b046df344706c631e);
    check("c3_st14", st8, {4'd14, 3'b101});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
